// File: rtl/uart_rx.sv
// 8N1-style UART receiver: oversampled start/data/stop recovery feeding a
// first-word-fall-through FIFO, with framing-error and overrun pulses.
module uart_rx #(
    parameter int WIDTH          = 8,
    parameter int SAMPLING_TICKS = 16,
    parameter int CLOCK_FREQ     = 100_000_000,
    parameter int BAUD_RATE      = 115200,
    parameter int DEPTH          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int DIV_RAW = CLOCK_FREQ / (BAUD_RATE * SAMPLING_TICKS);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW      = $clog2(SAMPLING_TICKS);
    localparam int BW      = $clog2(WIDTH + 1);
    localparam int AW      = $clog2(DEPTH);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(SAMPLING_TICKS - 1);
    localparam logic [TW-1:0] T_HALF   = TW'(SAMPLING_TICKS / 2 - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    logic             rx_meta, rx_s;
    logic [DW-1:0]    div_cnt;
    logic             tick;
    state_t           state;
    logic [TW-1:0]    tcnt;
    logic [BW-1:0]    bcnt;
    logic [WIDTH-1:0] shift_reg;
    logic             stop_sample, push, pop;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Free-running: the sampling phase relative to a start edge is allowed to drift by one tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= '0;
        else if (div_cnt == DIV_LAST)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DW'(1);
    end

    assign tick        = (div_cnt == DIV_LAST);
    assign stop_sample = (state == STOP) && tick && (tcnt == T_LAST);
    assign pop         = rd_en && !empty;
    assign push        = stop_sample && rx_s && (!full || rd_en);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tcnt      <= '0;
            bcnt      <= '0;
            shift_reg <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        tcnt  <= '0;
                        bcnt  <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tcnt == T_HALF) begin
                            tcnt  <= '0;
                            state <= rx_s ? IDLE : DATA;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tcnt == T_LAST) begin
                            shift_reg <= WIDTH'({rx_s, shift_reg} >> 1);
                            tcnt      <= '0;
                            bcnt      <= bcnt + BW'(1);
                            if (bcnt == B_LAST)
                                state <= STOP;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (tcnt == T_LAST) begin
                            tcnt <= '0;
                            if (!rx_s) begin
                                frame_err <= 1'b1;
                                state     <= WAIT_HIGH;
                            end else begin
                                overrun <= full && !rd_en;
                                state   <= IDLE;
                            end
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end
                // A held-low line (break) must not be mistaken for a new start bit.
                WAIT_HIGH: begin
                    if (rx_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= shift_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign data_out = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule
